mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle sequencer for the MIPS datapath. It replaces the single-cycle opcode decoder with a state machine that drives one shared ALU and one shared instruction/data memory port across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps. It supports R-type, jr, lw, sw, addi, andi, beq, j and jal, and stalls on a memory ready handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational, same cycle
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_en  out  1  PC register load
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],00}, 11 reg A
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_write  out  1  register file write
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 sext(imm), 11 sext(imm)<<2
- alu_op  out  3  000 R-type funct decode, 001 add (addr/PC), 010 add (addi), 011 and, 110 sub
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- halted  out  1  illegal opcode trapped; sticky until reset
- state  out  4  current state, for debug

## Operation
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11, JAL=12, JR=13, TRAP=14.
- Any output not listed for a state is 0.
- FETCH:
  - Asserts mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=001, pc_src=00.
  - ir_write and pc_en equal mem_ready (Mealy).
  - Holds while mem_ready=0. Goes to DECODE on mem_ready=1.
- DECODE:
  - Asserts alu_src_a=0, alu_src_b=11, alu_op=001, which precomputes the branch target into ALUOut.
  - Next state by op:
    - 000000: JR if funct=001000, else R_EXEC.
    - 100011 or 101011: MEM_ADDR.
    - 001000 or 001100: I_EXEC.
    - 000100: BRANCH.
    - 000010: JUMP.
    - 000011: JAL.
    - Any other op: TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=001. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1. Goes to FETCH.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready. On mem_ready, instr_done=1 and goes to FETCH. sw never asserts reg_write.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=000. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1. Goes to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=010 for addi or 011 for andi. Goes to I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01, pc_en=zero, instr_done=1. Goes to FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. Goes to FETCH.
- JAL: reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4), pc_src=10, pc_en=1, instr_done=1. Goes to FETCH. The register write and PC load happen on the same edge; the register file samples the old PC.
- JR: pc_src=11, pc_en=1, instr_done=1. Goes to FETCH.
- TRAP: halted=1. All write enables and memory requests stay 0. Remains in TRAP until reset.

## Timing
- Reset:
  - rst_n low forces state=FETCH asynchronously and gates every output to 0, including mem_read.
  - The first fetch request appears in the cycle after rst_n is sampled high.
  - Reset mid-instruction abandons the instruction with no write.
- Minimum latency in cycles, counted FETCH through the instr_done cycle:
  - lw: 5
  - sw, R-type, addi, andi: 4
  - beq, j, jal, jr: 3
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_read and mem_write stay asserted and stable (iord unchanged) until the mem_ready cycle.
- mem_ready is ignored in all other states.
- reg_write, mem_write, pc_en and ir_write are never high in the same cycle as any other of these, with two exceptions: FETCH (pc_en with ir_write) and JAL (reg_write with pc_en).
- instr_done is high for exactly one cycle per retired instruction and is never high in TRAP.

## Test plan
- Reset then one lw with mem_ready always 1: state sequence 0,1,2,3,4,0. reg_write=1, mem_to_reg=01 only in state 4. instr_done pulses once.
- sw with mem_ready low for 3 cycles in MEM_WR: mem_write=1 and iord=1 held for 4 cycles. reg_write never 1. Total 7 cycles.
- beq with zero=1, then zero=0: pc_en=1 with pc_src=01 in BRANCH for the first; pc_en=0 for the second. Each takes 3 cycles.
- jal: in JAL, reg_dst=10, mem_to_reg=10, reg_write=1, pc_en=1, pc_src=10 in the same cycle.
- op=000000 with funct=001000: DECODE goes to JR, pc_src=11, reg_write stays 0. Then op=111111: TRAP, halted=1 and held for 20 cycles with all enables 0.
- Assert rst_n low during MEM_RD while mem_ready=0: outputs go to 0 immediately. After release, state=0 and mem_read=1 with iord=0 from the next cycle.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control sequencer: one shared ALU and one shared memory port,
// stepped through fetch/decode/execute/memory/writeback states with a ready stall.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       instr_done,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_ADDI  = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b110;

    state_t state_q;
    state_t state_d;
    // run_q stays low through reset and for the cycle in which rst_n is first
    // sampled high, so every output is gated off until the first real fetch cycle.
    logic   run_q;

    logic       pc_en_c;
    logic [1:0] pc_src_c;
    logic       iord_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic [1:0] reg_dst_c;
    logic [1:0] mem_to_reg_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [2:0] alu_op_c;
    logic       instr_done_c;
    logic       halted_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_en_c      = 1'b0;
        pc_src_c     = 2'b00;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 2'b00;
        mem_to_reg_c = 2'b00;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        alu_op_c     = ALU_FUNCT;
        instr_done_c = 1'b0;
        halted_c     = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is written back in the same cycle the IR captures the word.
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                alu_op_c    = ALU_ADD;
                ir_write_c  = mem_ready;
                pc_en_c     = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                alu_op_c    = ALU_ADD;
                case (op)
                    OP_RTYPE: state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
                    OP_LW,
                    OP_SW:    state_d = S_MEM_ADDR;
                    OP_ADDI,
                    OP_ANDI:  state_d = S_I_EXEC;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    OP_JAL:   state_d = S_JAL;
                    default:  state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = ALU_ADD;
                state_d     = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = 2'b00;
                mem_to_reg_c = 2'b01;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (mem_ready) begin
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b00;
                alu_op_c    = ALU_FUNCT;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = 2'b01;
                mem_to_reg_c = 2'b00;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = (op == OP_ANDI) ? ALU_AND : ALU_ADDI;
                state_d     = S_I_WB;
            end
            S_I_WB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = 2'b00;
                mem_to_reg_c = 2'b00;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                // ALUOut holds the target computed in DECODE; the ALU now compares rs/rt.
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = 2'b00;
                alu_op_c     = ALU_SUB;
                pc_src_c     = 2'b01;
                pc_en_c      = zero;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_src_c     = 2'b10;
                pc_en_c      = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                // The register file samples the PC before this edge, i.e. PC+4.
                reg_write_c  = 1'b1;
                reg_dst_c    = 2'b10;
                mem_to_reg_c = 2'b10;
                pc_src_c     = 2'b10;
                pc_en_c      = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JR: begin
                pc_src_c     = 2'b11;
                pc_en_c      = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                halted_c = 1'b1;
                state_d  = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (!run_q) begin
            state_d = S_FETCH;
        end
    end

    assign pc_en      = run_q & pc_en_c;
    assign pc_src     = run_q ? pc_src_c : 2'b00;
    assign iord       = run_q & iord_c;
    assign mem_read   = run_q & mem_read_c;
    assign mem_write  = run_q & mem_write_c;
    assign ir_write   = run_q & ir_write_c;
    assign reg_write  = run_q & reg_write_c;
    assign reg_dst    = run_q ? reg_dst_c : 2'b00;
    assign mem_to_reg = run_q ? mem_to_reg_c : 2'b00;
    assign alu_src_a  = run_q & alu_src_a_c;
    assign alu_src_b  = run_q ? alu_src_b_c : 2'b00;
    assign alu_op     = run_q ? alu_op_c : 3'b000;
    assign instr_done = run_q & instr_done_c;
    assign halted     = run_q & halted_c;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: randomized instruction stream with memory stalls,
// checked per retired instruction against an instruction-level reference model.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       halted;
    logic [3:0] state;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .halted     (halted),
        .state      (state)
    );

    // Per-instruction signature: visited-state trace plus counts of enable cycles.
    typedef struct packed {
        logic [63:0] trace;
        logic [5:0]  cycles;
        logic [3:0]  n_fr;
        logic [3:0]  n_dr;
        logic [3:0]  n_mw;
        logic [3:0]  n_ir;
        logic [3:0]  n_pc;
        logic [3:0]  n_rw;
        logic [3:0]  n_both;
        logic [1:0]  rdst;
        logic [1:0]  m2r;
        logic [1:0]  psrc;
        logic [2:0]  alu_x;
    } rec_t;

    localparam int W = $bits(rec_t);
    logic [W-1:0] exp_q[$];

    int errors;
    int checks;
    int fs;
    int ds;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add_st(inout rec_t r, input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            r.trace  = {r.trace[59:0], s};
            r.cycles = r.cycles + 6'd1;
        end
    endfunction

    // Reference model: states visited and enable activity for one instruction.
    function automatic rec_t model(input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input int fsv, input int dsv);
        rec_t r;
        r = '0;
        add_st(r, 4'd0, fsv + 1);
        add_st(r, 4'd1, 1);
        r.n_fr = 4'(fsv + 1);
        r.n_ir = 4'd1;
        r.n_pc = 4'd1;
        case (o)
            6'h00: begin
                if (f == 6'h08) begin
                    add_st(r, 4'd13, 1);
                    r.n_pc = 4'd2;
                    r.psrc = 2'b11;
                end else begin
                    add_st(r, 4'd6, 1);
                    add_st(r, 4'd7, 1);
                    r.n_rw = 4'd1;
                    r.rdst = 2'b01;
                    r.alu_x = 3'b000;
                end
            end
            6'h23: begin
                add_st(r, 4'd2, 1);
                add_st(r, 4'd3, dsv + 1);
                add_st(r, 4'd4, 1);
                r.n_dr = 4'(dsv + 1);
                r.n_rw = 4'd1;
                r.m2r = 2'b01;
                r.alu_x = 3'b001;
            end
            6'h2b: begin
                add_st(r, 4'd2, 1);
                add_st(r, 4'd5, dsv + 1);
                r.n_mw = 4'(dsv + 1);
                r.alu_x = 3'b001;
            end
            6'h08, 6'h0c: begin
                add_st(r, 4'd8, 1);
                add_st(r, 4'd9, 1);
                r.n_rw = 4'd1;
                r.alu_x = (o == 6'h0c) ? 3'b011 : 3'b010;
            end
            6'h04: begin
                add_st(r, 4'd10, 1);
                r.alu_x = 3'b110;
                r.psrc = 2'b01;
                if (z) r.n_pc = 4'd2;
            end
            6'h02: begin
                add_st(r, 4'd11, 1);
                r.n_pc = 4'd2;
                r.psrc = 2'b10;
            end
            default: begin
                add_st(r, 4'd12, 1);
                r.n_pc = 4'd2;
                r.n_rw = 4'd1;
                r.n_both = 4'd1;
                r.rdst = 2'b10;
                r.m2r = 2'b10;
                r.psrc = 2'b10;
            end
        endcase
        return r;
    endfunction

    // Memory responder: completes a request after fs (fetch) or ds (data) wait cycles.
    initial begin
        int wcnt;
        int tgt;
        wcnt = 0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_ready = 1'b0;
                wcnt = 0;
            end else if (mem_read || mem_write) begin
                tgt = iord ? ds : fs;
                if (wcnt >= tgt) begin
                    mem_ready = 1'b1;
                    wcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt = wcnt + 1;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                wcnt = 0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        rec_t a;
        rec_t e;
        logic prev_dec;
        int   nen;
        a = '0;
        prev_dec = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a = '0;
                prev_dec = 1'b0;
            end else begin
                a.trace  = {a.trace[59:0], state};
                a.cycles = a.cycles + 6'd1;
                if (mem_read && !iord) a.n_fr = a.n_fr + 4'd1;
                if (mem_read && iord)  a.n_dr = a.n_dr + 4'd1;
                if (mem_write)         a.n_mw = a.n_mw + 4'd1;
                if (ir_write)          a.n_ir = a.n_ir + 4'd1;
                if (pc_en)             a.n_pc = a.n_pc + 4'd1;
                if (reg_write) begin
                    a.n_rw = a.n_rw + 4'd1;
                    a.rdst = reg_dst;
                    a.m2r  = mem_to_reg;
                end
                if (reg_write && pc_en) a.n_both = a.n_both + 4'd1;
                if (prev_dec) a.alu_x = alu_op;
                prev_dec = (state == 4'd1);

                nen = int'(reg_write) + int'(mem_write) + int'(pc_en) + int'(ir_write);
                chk("enable_exclusive",
                    64'((nen <= 1) || (nen == 2 && ((pc_en && ir_write) || (reg_write && pc_en)))), 64'd1);

                if (instr_done) begin
                    a.psrc = pc_src;
                    chk("done_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = rec_t'(exp_q.pop_front());
                        chk("state_trace", a.trace, e.trace);
                        chk("cycles", 64'(a.cycles), 64'(e.cycles));
                        chk("fetch_reads", 64'(a.n_fr), 64'(e.n_fr));
                        chk("data_reads", 64'(a.n_dr), 64'(e.n_dr));
                        chk("mem_writes", 64'(a.n_mw), 64'(e.n_mw));
                        chk("ir_writes", 64'(a.n_ir), 64'(e.n_ir));
                        chk("pc_loads", 64'(a.n_pc), 64'(e.n_pc));
                        chk("reg_writes", 64'(a.n_rw), 64'(e.n_rw));
                        chk("rw_with_pc", 64'(a.n_both), 64'(e.n_both));
                        chk("reg_dst", 64'(a.rdst), 64'(e.rdst));
                        chk("mem_to_reg", 64'(a.m2r), 64'(e.m2r));
                        chk("pc_src_done", 64'(a.psrc), 64'(e.psrc));
                        chk("exec_alu_op", 64'(a.alu_x), 64'(e.alu_x));
                    end
                    a = '0;
                    prev_dec = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int fsv, input int dsv, input bit push);
        op = o;
        funct = f;
        zero = z;
        fs = fsv;
        ds = dsv;
        if (push) exp_q.push_back(W'(model(o, f, z, fsv, dsv)));
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(got), 64'd1);
        #1;
    endtask

    task automatic run_one(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fsv, input int dsv);
        issue(o, f, z, fsv, dsv, 1'b1);
        wait_done();
    endtask

    function automatic logic [19:0] out_vec();
        return {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, halted};
    endfunction

    logic [5:0] legal_ops [9];

    initial begin
        bit seen;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        op = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        fs = 0;
        ds = 0;
        legal_ops = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h08, 6'h0c, 6'h04, 6'h02, 6'h03};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(out_vec()), 64'd0);
        chk("reset_state", 64'(state), 64'd0);

        // lw with no stalls, issued before reset is released
        issue(6'h23, 6'h00, 1'b0, 0, 0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("first_fetch", 64'({state, mem_read, iord}), 64'({4'd0, 1'b1, 1'b0}));
        wait_done();

        run_one(6'h2b, 6'h00, 1'b0, 0, 3);
        run_one(6'h04, 6'h00, 1'b1, 0, 0);
        run_one(6'h04, 6'h00, 1'b0, 0, 0);
        run_one(6'h03, 6'h00, 1'b0, 0, 0);
        run_one(6'h00, 6'h08, 1'b0, 0, 0);
        run_one(6'h00, 6'h20, 1'b0, 1, 0);
        run_one(6'h08, 6'h00, 1'b0, 0, 0);
        run_one(6'h0c, 6'h00, 1'b0, 2, 0);
        run_one(6'h02, 6'h00, 1'b0, 0, 0);
        run_one(6'h23, 6'h00, 1'b0, 3, 3);

        for (int i = 0; i < 40; i++) begin
            int k;
            logic [5:0] f;
            k = $urandom_range(0, 8);
            f = 6'($urandom_range(0, 63));
            if (k == 3) f = 6'h08;
            run_one(legal_ops[k], f, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // illegal opcode: sticky trap
        issue(6'h3f, 6'h00, 1'b0, 0, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (halted) begin
                seen = 1'b1;
                break;
            end
        end
        chk("trap_entered", 64'(seen), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("trap_hold", 64'({halted, state, pc_en, ir_write, reg_write, mem_write, mem_read, instr_done}),
                64'({1'b1, 4'd14, 6'b000000}));
        end

        // reset while lw is stalled in its data read
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        issue(6'h23, 6'h00, 1'b0, 0, 15, 1'b0);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (state == 4'd3) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reached_mem_rd", 64'(seen), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 64'(out_vec()), 64'd0);
        chk("midreset_state", 64'(state), 64'd0);
        @(negedge clk);
        issue(6'h08, 6'h00, 1'b0, 0, 0, 1'b1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("refetch", 64'({state, mem_read, iord}), 64'({4'd0, 1'b1, 1'b0}));
        wait_done();

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
